// File: rtl/frame_loader_pkg.sv
// frame_loader shared types and sizes.
// Widths for the 19x6-bit operand bank and its FSM.
package frame_loader_pkg;

  localparam int NUM_WORDS = 19;
  localparam int WIDTH     = 6;
  localparam int CNT_W     = 5;
  localparam int SUM_W     = 11;
  localparam int BUS_W     = NUM_WORDS * WIDTH;
  localparam int SUM_MAX   = (1 << WIDTH) - 1;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SUM  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/loader_bank.sv
// loader_bank: 19x6 operand register bank, flat output bus.
// Ports: clk, rst_n, we, idx, wdata in; nums out (slot k at [k*6 +: 6]).
module loader_bank
  import frame_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [CNT_W-1:0] idx,
  input  logic [WIDTH-1:0] wdata,
  output logic [BUS_W-1:0] nums
);

  logic [WIDTH-1:0] mem [NUM_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_WORDS; k++)
        mem[k] <= '0;
    end else if (we) begin
      for (int k = 0; k < NUM_WORDS; k++)
        if (idx == CNT_W'(k))
          mem[k] <= wdata;
    end
  end

  always_comb begin
    nums = '0;
    for (int k = 0; k < NUM_WORDS; k++)
      nums[k*WIDTH +: WIDTH] = mem[k];
  end

endmodule

// File: rtl/frame_loader.sv
// frame_loader: serial operand loader for the 19-input summing stage.
// Ports: in_data/in_valid/in_ready word input, frame_clr abort,
//   nums bank bus, sum_in from adder, result/result_valid/result_ready
//   output; result_ovf only when LOADER_OVF_EN is defined.
module frame_loader
  import frame_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             frame_clr,
  output logic [BUS_W-1:0] nums,
  input  logic [WIDTH-1:0] sum_in,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
`ifdef LOADER_OVF_EN
  ,
  output logic             result_ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             armed;
  logic             wr_en;
  logic             load_res;
  logic             start;

  // armed keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FILL;
      cnt    <= '0;
      armed  <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      armed <= 1'b1;
      if (load_res)
        result <= sum_in;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    wr_en        = 1'b0;
    load_res     = 1'b0;
    start        = 1'b0;
    in_ready     = 1'b0;
    result_valid = 1'b0;
    unique case (state)
      FILL: begin
        in_ready = armed;
        // abort beats a coincident accept
        if (frame_clr) begin
          cnt_nx = '0;
        end else if (in_valid && armed) begin
          wr_en = 1'b1;
          if (cnt == LAST) begin
            cnt_nx   = '0;
            state_nx = SUM;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      SUM: begin
        load_res = 1'b1;
        state_nx = HOLD;
      end
      HOLD: begin
        result_valid = 1'b1;
        if (result_ready) begin
          start    = 1'b1;
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  loader_bank u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .idx   (cnt),
    .wdata (in_data),
    .nums  (nums)
  );

`ifdef LOADER_OVF_EN
  logic [SUM_W-1:0] run_sum;
  logic             clr_sum;

  assign clr_sum = start || ((state == FILL) && frame_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_sum    <= '0;
      result_ovf <= 1'b0;
    end else begin
      if (clr_sum)
        run_sum <= '0;
      else if (wr_en)
        run_sum <= run_sum + SUM_W'(in_data);
      if (load_res)
        result_ovf <= (run_sum > SUM_W'(SUM_MAX));
    end
  end
`endif

endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: directed bench for frame_loader.
// Loops a behavioural 19-input adder back into sum_in.
module tb_frame_loader;
  import frame_loader_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             frame_clr;
  logic [BUS_W-1:0] nums;
  logic [WIDTH-1:0] sum_in;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             result_ready;
`ifdef LOADER_OVF_EN
  logic             result_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] vec [NUM_WORDS];

  frame_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .frame_clr    (frame_clr),
    .nums         (nums),
    .sum_in       (sum_in),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
`ifdef LOADER_OVF_EN
    ,
    .result_ovf   (result_ovf)
`endif
  );

  always #5 clk = ~clk;

  int acc;
  always_comb begin
    acc = 0;
    for (int k = 0; k < NUM_WORDS; k++)
      acc += int'(nums[k*WIDTH +: WIDTH]);
    sum_in = WIDTH'(acc);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int slot(input int k);
    return int'(nums[k*WIDTH +: WIDTH]);
  endfunction

  task automatic send(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      int b;
      b = 0;
      if (gap && i > 0) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data  = vec[i];
      while (!in_ready && b < 40) begin
        step();
        b++;
      end
      if (!in_ready)
        check("in_ready_wait", 0, 1);
      step();
    end
    in_valid = 1'b0;
  endtask

  // call in the SUM cycle, right after the last accept
  task automatic expect_res(input string tag, input int r,
                            input int ovf);
    check({tag, "_sum_valid"}, int'(result_valid), 0);
    check({tag, "_sum_ready"}, int'(in_ready), 0);
    step();
    check({tag, "_valid"}, int'(result_valid), 1);
    check({tag, "_result"}, int'(result), r);
`ifdef LOADER_OVF_EN
    check({tag, "_ovf"}, int'(result_ovf), ovf);
`else
    if (ovf < 0)
      $display("bad ovf arg");
`endif
  endtask

  task automatic take(input string tag);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check({tag, "_taken_valid"}, int'(result_valid), 0);
    check({tag, "_taken_ready"}, int'(in_ready), 1);
  endtask

  task automatic fill(input int mode, input int v);
    for (int i = 0; i < NUM_WORDS; i++)
      vec[i] = (mode == 0) ? WIDTH'(i + 1) : WIDTH'(v);
  endtask

  initial begin
    bit ok;
    rst_n        = 1'b0;
    in_data      = '0;
    in_valid     = 1'b0;
    frame_clr    = 1'b0;
    result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_valid", int'(result_valid), 0);
    check("rst_result", int'(result), 0);
    check("rst_nums_zero", int'(nums == '0), 1);
`ifdef LOADER_OVF_EN
    check("rst_ovf", int'(result_ovf), 0);
`endif
    rst_n = 1'b1;
    check("rel_in_ready", int'(in_ready), 0);
    step();
    check("armed_in_ready", int'(in_ready), 1);

    // words 1..19: 190 mod 64 = 62
    fill(0, 0);
    send(NUM_WORDS, 1'b0);
    expect_res("t1", 62, 1);
    check("t1_slot0", slot(0), 1);
    check("t1_slot18", slot(18), 19);
    take("t1");

    // all 3: 57, held while result_ready low
    fill(1, 3);
    send(NUM_WORDS, 1'b0);
    expect_res("t2", 57, 0);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!result_valid || result != 6'd57 || in_ready)
        ok = 1'b0;
    end
    check("t2_hold_stable", int'(ok), 1);
    take("t2");

    // 7 words of 9, abort with an 8th word, then 19 ones
    fill(1, 9);
    send(7, 1'b0);
    in_valid  = 1'b1;
    in_data   = 6'd50;
    frame_clr = 1'b1;
    step();
    frame_clr = 1'b0;
    in_valid  = 1'b0;
    check("t3_slot6", slot(6), 9);
    check("t3_slot7_dropped", slot(7), 3);
    fill(1, 1);
    send(NUM_WORDS, 1'b0);
    expect_res("t3", 19, 0);
    check("t3_slot7", slot(7), 1);
    take("t3");

    // in_valid every other cycle, 63s: 1197 mod 64 = 45
    fill(1, 63);
    send(NUM_WORDS, 1'b1);
    expect_res("t4", 45, 1);
    ok = 1'b1;
    for (int k = 0; k < NUM_WORDS; k++)
      if (slot(k) != 63)
        ok = 1'b0;
    check("t4_all_slots", int'(ok), 1);
    take("t4");

    // reset in HOLD
    fill(0, 0);
    send(NUM_WORDS, 1'b0);
    step();
    check("t5_in_hold", int'(result_valid), 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", int'(result_valid), 0);
    check("t5_rst_nums", int'(nums == '0), 1);
    check("t5_rst_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("t5_rearmed", int'(in_ready), 1);
    // reset at cnt=10
    fill(1, 7);
    send(10, 1'b0);
    check("t5_slot9", slot(9), 7);
    rst_n = 1'b0;
    #1;
    check("t5_mid_nums", int'(nums == '0), 1);
    check("t5_mid_valid", int'(result_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    fill(1, 2);
    send(NUM_WORDS, 1'b0);
    expect_res("t5", 38, 0);
    check("t5_slot10", slot(10), 2);
    take("t5");

    // frame_clr during SUM and HOLD: 95 mod 64 = 31
    fill(1, 5);
    send(NUM_WORDS, 1'b0);
    frame_clr = 1'b1;
    expect_res("t6", 31, 1);
    step();
    check("t6_hold_valid", int'(result_valid), 1);
    check("t6_hold_result", int'(result), 31);
    frame_clr = 1'b0;
    take("t6");
    step();
    check("t6_once", int'(result_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
